pipe_reg_chain: RTL

//   Parametrised elastic pipeline register: DEPTH stages of WIDTH-bit data, each with a valid bit.

---
 rtl/pipe_reg_chain_pkg.sv | 12 +
 rtl/pipe_reg_chain_stage.sv | 61 ++++++
 rtl/pipe_reg_chain.sv | 87 ++++++++
 3 files changed

// File: rtl/pipe_reg_chain_pkg.sv
// Shared types for the elastic pipeline register chain.
package pipe_reg_chain_pkg;

    // What a single slot does at the next clock edge. Reset is handled
    // separately, because it overrides every other action.
    typedef enum logic [1:0] {
        OP_HOLD,
        OP_LOAD,
        OP_FLUSH
    } stage_op_t;

endpackage

// File: rtl/pipe_reg_chain_stage.sv
// One slot of the elastic pipeline: a valid bit, a data word and the
// take signal that feeds the ready chain in the top module.
module pipe_stage
    import pipe_reg_chain_pkg::*;
#(
    parameter int              WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter bit              CLEAR_DATA  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             move,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             take
);

    stage_op_t op;

    // The slot can take a new entry when it is empty or its entry leaves this edge.
    assign take = !valid || move;

    // Pick the slot action; flush beats load, and everything else holds.
    always_comb begin
        op = OP_HOLD;
        if (flush) begin
            op = OP_FLUSH;
        end else if (take) begin
            op = OP_LOAD;
        end
    end

    // Slot register: a bubble moves in without disturbing the held data word.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= RESET_VALUE;
        end else begin
            case (op)
                OP_FLUSH: begin
                    valid <= 1'b0;
                    if (CLEAR_DATA) begin
                        data <= RESET_VALUE;
                    end
                end
                OP_LOAD: begin
                    valid <= prev_valid;
                    if (prev_valid) begin
                        data <= prev_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic pipeline register: DEPTH valid/ready slots with bubble collapse,
// flush and an occupancy counter.
module pipe_reg_chain
    import pipe_reg_chain_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               DEPTH       = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter bit               CLEAR_DATA  = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);

    if (DEPTH < 1) begin : g_bad_depth
        $error("pipe_reg_chain: DEPTH must be at least 1");
    end

    logic             stage_valid [DEPTH];
    logic [WIDTH-1:0] stage_data  [DEPTH];
    logic             stage_take  [DEPTH];
    logic             stage_move  [DEPTH];
    logic             acc_in;
    logic             acc_out;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             prev_valid;
        logic [WIDTH-1:0] prev_data;

        if (i == 0) begin : g_head
            assign prev_valid = in_valid;
            assign prev_data  = in_data;
        end else begin : g_body
            assign prev_valid = stage_valid[i-1];
            assign prev_data  = stage_data[i-1];
        end

        // Ready ripples back from the output: a slot's entry moves when the next slot takes.
        if (i == DEPTH - 1) begin : g_tail
            assign stage_move[i] = out_ready;
        end else begin : g_mid
            assign stage_move[i] = stage_take[i+1];
        end

        pipe_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE),
            .CLEAR_DATA  (CLEAR_DATA)
        ) u_stage (
            .clk        (clk),
            .reset      (reset),
            .flush      (flush),
            .move       (stage_move[i]),
            .prev_valid (prev_valid),
            .prev_data  (prev_data),
            .valid      (stage_valid[i]),
            .data       (stage_data[i]),
            .take       (stage_take[i])
        );
    end

    assign in_ready  = stage_take[0] && !flush && !reset;
    assign out_valid = stage_valid[DEPTH-1];
    assign out_data  = stage_data[DEPTH-1];
    assign acc_in    = in_valid && in_ready;
    assign acc_out   = out_valid && out_ready;

    // Occupancy: an output handshake during flush is consumed, so both clear to zero.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count <= '0;
        end else begin
            count <= count + CW'(acc_in) - CW'(acc_out);
        end
    end

endmodule
